// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The fetch unit has an optional feature enabled by RANGER_FETCH_BYPASS_EN.
package fetch_unit_pkg;

    localparam logic [31:0]  DEFAULT_ROM_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0]  DEFAULT_RESET_ADDR    = DEFAULT_ROM_BASE_ADDR;
    localparam int unsigned  DEFAULT_IBUF_DEPTH    = 2;

    // One buffered fetch result as presented to Decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        access_fault;
        logic        misaligned;
    } fetch_entry_t;

    // RUN fetches, MISALIGN emits the misaligned-redirect entry, HALT waits for redirect
    typedef enum logic [1:0] {
        ST_RUN,
        ST_MISALIGN,
        ST_HALT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetch entries with flush, occupancy count and
// simultaneous push/pop. DEPTH must be a power of two.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_IBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Entry storage; cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: drives the ibus read port, buffers responses
// and hands them to Decode with a valid/ready handshake.
// Optional feature: RANGER_FETCH_BYPASS_EN lets a response reach Decode in
// the cycle it arrives when the buffer is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int unsigned IBUF_DEPTH = DEFAULT_IBUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ibus_rd_en,
    output logic [31:0] ibus_addr,
    input  logic [31:0] ibus_rd_data,
    input  logic        ibus_inst_access_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_access_fault,
    output logic        inst_misaligned
);

    localparam int unsigned AW = $clog2(IBUF_DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic          pending;
    logic [31:0]   pending_pc;
    logic          pending_fault;

    fetch_entry_t  resp_entry;
    fetch_entry_t  head_entry;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [AW:0]   fifo_count;
    logic [AW+1:0] occupancy;

    logic          resp_valid;
    logic          bypass_valid;
    logic          deq;
    logic          issue;

    // Response for last cycle's read, unless a redirect squashes it
    assign resp_valid = pending & ~redirect;
    assign resp_entry = '{pc: pending_pc,
                          inst: pending_fault ? '0 : ibus_rd_data,
                          access_fault: pending_fault,
                          misaligned: 1'b0};

`ifdef RANGER_FETCH_BYPASS_EN
    assign bypass_valid = fifo_empty & resp_valid;
`else
    assign bypass_valid = 1'b0;
`endif

    assign inst_valid = ~fifo_empty | bypass_valid;
    assign deq        = inst_valid & inst_ready & ~redirect;
    assign fifo_pop   = deq & ~fifo_empty;

    // Head presented to Decode: the live response while bypassing, else the buffer head
    always_comb begin
        head_entry = fifo_head;
        if (bypass_valid) begin
            head_entry = resp_entry;
        end
        inst              = head_entry.inst;
        inst_pc           = head_entry.pc;
        inst_access_fault = head_entry.access_fault;
        inst_misaligned   = head_entry.misaligned;
    end

    // Buffer write: misaligned-redirect marker or a response not consumed by bypass
    always_comb begin
        fifo_push  = 1'b0;
        push_entry = resp_entry;
        if (!redirect && state == ST_MISALIGN) begin
            fifo_push  = 1'b1;
            push_entry = '{pc: pc, inst: '0, access_fault: 1'b0, misaligned: 1'b1};
        end else if (resp_valid && !(bypass_valid && inst_ready)) begin
            fifo_push  = 1'b1;
        end
    end

    // Issue gating: room must exist for everything already owed to the buffer.
    // A faulted response in flight also blocks issue so nothing is fetched past it.
    always_comb begin
        occupancy = (AW+2)'(fifo_count) + (AW+2)'(pending) - (AW+2)'(deq);
        issue     = rst_n & (state == ST_RUN) & ~redirect
                    & ~(pending & pending_fault)
                    & (occupancy < (AW+2)'(IBUF_DEPTH));
        ibus_rd_en = issue;
        ibus_addr  = pc;
    end

    // Next PC and state; redirect takes priority over everything else
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect) begin
            pc_next    = redirect_addr;
            state_next = is_misaligned(redirect_addr) ? ST_MISALIGN : ST_RUN;
        end else begin
            if (issue) begin
                pc_next = pc + 32'd4;
            end
            case (state)
                ST_RUN:      if (resp_valid && pending_fault) state_next = ST_HALT;
                ST_MISALIGN: state_next = ST_HALT;
                default:     state_next = state;
            endcase
        end
    end

    // State, PC and in-flight request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            pc            <= RESET_ADDR;
            pending       <= 1'b0;
            pending_pc    <= '0;
            pending_fault <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pending <= issue;
            if (issue) begin
                pending_pc    <= pc;
                pending_fault <= ibus_inst_access_fault;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(IBUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;
`ifdef RANGER_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          acc;
        bit          mis;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_rd_en;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rd_data;
    logic        ibus_inst_access_fault;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_access_fault;
    logic        inst_misaligned;

    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'hFFFF_FFF0;

    int checks = 0;
    int failures = 0;

    // model state
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_mis_due;
    bit          m_inflight;
    logic [31:0] m_if_pc;
    bit          m_if_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_ADDR(RST_ADDR),
        .IBUF_DEPTH(DEPTH)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ibus_rd_en             (ibus_rd_en),
        .ibus_addr              (ibus_addr),
        .ibus_rd_data           (ibus_rd_data),
        .ibus_inst_access_fault (ibus_inst_access_fault),
        .redirect               (redirect),
        .redirect_addr          (redirect_addr),
        .inst_valid             (inst_valid),
        .inst_ready             (inst_ready),
        .inst                   (inst),
        .inst_pc                (inst_pc),
        .inst_access_fault      (inst_access_fault),
        .inst_misaligned        (inst_misaligned)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // ROM with one cycle of read latency; fault is combinational on address
    always @(posedge clk) ibus_rd_data <= rom_word(ibus_addr);
    assign ibus_inst_access_fault = fault_en && (ibus_addr == fault_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_pc       = RST_ADDR;
        m_halted   = 0;
        m_mis_due  = 0;
        m_inflight = 0;
        m_if_pc    = '0;
        m_if_fault = 0;
    endfunction

    // Reference model: compare at negedge, then advance to the next edge
    always @(negedge clk) begin
        ent_t head;
        ent_t r;
        bit   hv;
        bit   bypass_hit;
        bit   deq;
        bit   exp_rd;
        int   occ;
        if (!rst_n) begin
            model_reset();
            chk("rst_rd_en", ibus_rd_en, 0);
            chk("rst_valid", inst_valid, 0);
        end else begin
            r.pc   = m_if_pc;
            r.acc  = m_if_fault;
            r.mis  = 0;
            r.inst = m_if_fault ? 32'd0 : rom_word(m_if_pc);
            hv = 0;
            bypass_hit = 0;
            head = r;
            if (q.size() > 0) begin
                head = q[0];
                hv = 1;
            end else if (BYPASS && m_inflight && !redirect) begin
                hv = 1;
                bypass_hit = 1;
            end
            deq = hv && inst_ready && !redirect;
            occ = q.size() + int'(m_inflight) - int'(deq);
            exp_rd = !m_halted && !m_mis_due && !redirect
                     && !(m_inflight && m_if_fault) && occ < DEPTH;

            chk("rd_en", ibus_rd_en, exp_rd);
            chk("addr", ibus_addr, m_pc);
            chk("valid", inst_valid, hv);
            if (hv) begin
                chk("inst", inst, head.inst);
                chk("inst_pc", inst_pc, head.pc);
                chk("acc_fault", inst_access_fault, head.acc);
                chk("misaligned", inst_misaligned, head.mis);
            end

            if (redirect) begin
                q.delete();
                m_inflight = 0;
                m_pc       = redirect_addr;
                m_halted   = 0;
                m_mis_due  = (redirect_addr[1:0] != 2'b00);
            end else begin
                if (deq && !bypass_hit) void'(q.pop_front());
                if (m_mis_due) begin
                    q.push_back('{pc: m_pc, inst: 32'd0, acc: 0, mis: 1});
                    m_mis_due = 0;
                    m_halted  = 1;
                end
                if (m_inflight) begin
                    if (!(bypass_hit && deq)) q.push_back(r);
                    if (r.acc) m_halted = 1;
                end
                m_inflight = exp_rd;
                if (exp_rd) begin
                    m_if_pc    = m_pc;
                    m_if_fault = fault_en && (m_pc == fault_addr);
                    m_pc       = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        step();
        redirect      = 1'b1;
        redirect_addr = a;
        step();
        redirect      = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        bit          ok;
        int          rd_cnt;
        bit          seen;
        logic [31:0] s_pc;
        logic [31:0] s_inst;
        logic        s_acc;
        logic        s_mis;

        // Reset and first-instruction latency, ROM word i = i
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("c0_rd_en", ibus_rd_en, 1);
        chk("c0_addr", ibus_addr, RST_ADDR);
        @(negedge clk);
        chk("c1_valid", inst_valid, BYPASS);
        @(negedge clk);
        chk("c2_valid", inst_valid, 1);
        chk("c2_inst", inst, BYPASS ? 32'd1 : 32'd0);
        chk("c2_pc", inst_pc, BYPASS ? 32'h4 : 32'h0);
        @(negedge clk);
        chk("c3_inst", inst, BYPASS ? 32'd2 : 32'd1);
        chk("c3_pc", inst_pc, BYPASS ? 32'h8 : 32'h4);

        // Decode stalled: exactly DEPTH reads from a fresh start
        step();
        inst_ready = 1'b0;
        do_redirect(32'h200);
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ibus_rd_en) rd_cnt++;
        end
        chk("stall_reads", rd_cnt, DEPTH);
        chk("stall_head_pc", inst_pc, 32'h200);
        step();
        inst_ready = 1'b1;
        repeat (6) step();

        // Redirect with a response in flight
        do_redirect(32'h40);
        @(negedge clk);
        chk("redir_empty", inst_valid, 0);
        wait_valid("redir_timeout", ok);
        chk("redir_pc", inst_pc, 32'h40);
        repeat (4) step();

        // Access fault at 0x100 halts fetch
        fault_addr = 32'h100;
        fault_en   = 1'b1;
        do_redirect(32'h100);
        wait_valid("fault_timeout", ok);
        chk("fault_flag", inst_access_fault, 1);
        chk("fault_inst", inst, 0);
        chk("fault_pc", inst_pc, 32'h100);
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ibus_rd_en) rd_cnt++;
        end
        chk("fault_halt_reads", rd_cnt, 0);
        fault_en = 1'b0;
        do_redirect(32'h0);
        @(negedge clk);
        chk("resume_rd_en", ibus_rd_en, 1);
        chk("resume_addr", ibus_addr, 32'h0);
        repeat (4) step();

        // Misaligned redirect
        do_redirect(32'h42);
        rd_cnt = 0;
        seen   = 0;
        s_pc = '0; s_inst = '1; s_acc = 1'b1; s_mis = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ibus_rd_en) rd_cnt++;
            if (inst_valid && !seen) begin
                seen   = 1;
                s_pc   = inst_pc;
                s_inst = inst;
                s_acc  = inst_access_fault;
                s_mis  = inst_misaligned;
            end
        end
        chk("mis_reads", rd_cnt, 0);
        chk("mis_seen", seen, 1);
        chk("mis_pc", s_pc, 32'h42);
        chk("mis_flag", s_mis, 1);
        chk("mis_acc", s_acc, 0);
        chk("mis_inst", s_inst, 0);
        do_redirect(32'h80);
        repeat (5) step();

        // Reset mid-stream clears outputs at once
        rst_n = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_rd_en", ibus_rd_en, 0);
        chk("arst_inst", inst, 0);
        chk("arst_pc", inst_pc, 0);
        chk("arst_faults", {inst_access_fault, inst_misaligned}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rd_en", ibus_rd_en, 1);
        chk("rel_addr", ibus_addr, RST_ADDR);
        @(negedge clk);
        chk("rel_c1_valid", inst_valid, BYPASS);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            step();
            inst_ready = ($urandom % 10) < 7;
            fault_en   = ($urandom % 4) == 0;
            fault_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            redirect   = ($urandom % 25) == 0;
            sel = $urandom % 10;
            if (sel < 8)      redirect_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            else if (sel < 9) redirect_addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else              redirect_addr = 32'hFFFF_FFF4;
        end
        step();
        redirect = 1'b0;
        fault_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
